// File: rtl/serial_uart_pkg.sv
// Shared constants for serial_uart: register offsets, STATUS bit positions, FSM encodings.
// The RX storage depth is selected by SERIAL_UART_RX_FIFO_EN in serial_uart.
package serial_uart_pkg;

   localparam logic [3:0] AddrData   = 4'd0;
   localparam logic [3:0] AddrStatus = 4'd1;

   localparam int unsigned StatRxValid    = 0;
   localparam int unsigned StatTxBusy     = 1;
   localparam int unsigned StatOverrun    = 2;
   localparam int unsigned StatFramingErr = 3;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/serial_uart_rx.sv
// Receiver: 2-flop synchronizer, start-bit glitch rejection, mid-bit sampling, stop check.
// Emits a one-cycle push with the byte, or a one-cycle framing-error pulse.
module serial_uart_rx
   import serial_uart_pkg::*;
#(
   parameter int unsigned clocksPerBit = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serialIn,
   output logic       push,
   output logic [7:0] rx_byte,
   output logic       framing_err
);

   localparam logic [7:0] BitLast  = 8'(clocksPerBit - 1);
   localparam logic [7:0] HalfLast = 8'(clocksPerBit / 2 - 1);

   logic       meta_q, sync_q;
   rx_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic       wait_high_q, wait_high_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q      <= 1'b1;
         sync_q      <= 1'b1;
         state_q     <= RxIdle;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         wait_high_q <= 1'b0;
      end else begin
         meta_q      <= serialIn;
         sync_q      <= meta_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         wait_high_q <= wait_high_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 8'd1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      wait_high_d = wait_high_q;
      push        = 1'b0;
      framing_err = 1'b0;
      case (state_q)
         RxIdle: begin
            cnt_d = '0;
            bit_d = '0;
            // IDLE is only reached with the line high, so a low level here is the falling edge.
            if (!sync_q) state_d = RxStart;
         end
         RxStart: begin
            if (cnt_q == HalfLast) begin
               cnt_d   = '0;
               state_d = sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (cnt_q == BitLast) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RxStop;
            end
         end
         RxStop: begin
            if (wait_high_q) begin
               cnt_d = '0;
               if (sync_q) begin
                  wait_high_d = 1'b0;
                  state_d     = RxIdle;
               end
            end else if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (sync_q) begin
                  push    = 1'b1;
                  state_d = RxIdle;
               end else begin
                  framing_err = 1'b1;
                  wait_high_d = 1'b1;
               end
            end
         end
         default: state_d = RxIdle;
      endcase
   end

   assign rx_byte = shift_q;

endmodule

// File: rtl/serial_uart.sv
// Memory-mapped UART: DATA/STATUS registers, TX serializer and RX storage.
// SERIAL_UART_RX_FIFO_EN selects a 4-entry RX FIFO; otherwise a single holding register.
module serial_uart
   import serial_uart_pkg::*;
#(
   parameter int unsigned clocksPerBit = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] addr,
   input  logic [7:0] dataIn,
   output logic [7:0] dataOut,
   input  logic       strobe,
   input  logic       write,
   input  logic       serialIn,
   output logic       serialOut,
   output logic       rxReady
);

   localparam logic [7:0] BitLast = 8'(clocksPerBit - 1);

   logic wr_data, wr_status, rd_data;
   assign wr_data   = strobe & write & (addr == AddrData);
   assign wr_status = strobe & write & (addr == AddrStatus);
   assign rd_data   = strobe & ~write & (addr == AddrData);

   // ---------------- TX ----------------
   tx_state_e  tx_state_q, tx_state_d;
   logic [7:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       tx_busy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 8'd1;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TxIdle: begin
            tx_cnt_d = '0;
            tx_bit_d = '0;
            if (wr_data) begin
               tx_shift_d = dataIn;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_state_d = TxData;
            end
         end
         TxData: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TxStop;
            end
         end
         TxStop: begin
            if (tx_cnt_q == BitLast) begin
               tx_cnt_d   = '0;
               tx_state_d = TxIdle;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   always_comb begin
      serialOut = 1'b1;
      case (tx_state_q)
         TxStart: serialOut = 1'b0;
         TxData:  serialOut = tx_shift_q[0];
         default: serialOut = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state_q != TxIdle);

   // ---------------- RX ----------------
   logic       rx_push, rx_ferr;
   logic [7:0] rx_byte;

   serial_uart_rx #(
      .clocksPerBit(clocksPerBit)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .serialIn   (serialIn),
      .push       (rx_push),
      .rx_byte    (rx_byte),
      .framing_err(rx_ferr)
   );

   logic       rx_valid, rx_full, rx_pop, rx_accept;
   logic [7:0] rx_head;

`ifdef SERIAL_UART_RX_FIFO_EN
   logic [7:0] fifo_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q;

   assign rx_valid  = (count_q != 3'd0);
   assign rx_full   = (count_q == 3'd4);
   assign rx_pop    = rd_data & rx_valid;
   // A pop in the same cycle frees the slot the new byte needs.
   assign rx_accept = rx_push & (~rx_full | rx_pop);
   assign rx_head   = fifo_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (rx_accept) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (rx_pop)    rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({rx_accept, rx_pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rx_accept) fifo_q[wr_ptr_q] <= rx_byte;
   end
`else
   logic [7:0] hold_q;
   logic       hold_valid_q;

   assign rx_valid  = hold_valid_q;
   assign rx_full   = hold_valid_q;
   assign rx_pop    = rd_data & rx_valid;
   assign rx_accept = rx_push & (~rx_full | rx_pop);
   assign rx_head   = hold_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         if (rx_accept) begin
            hold_q       <= rx_byte;
            hold_valid_q <= 1'b1;
         end else if (rx_pop) begin
            hold_valid_q <= 1'b0;
         end
      end
   end
`endif

   // ---------------- status flags ----------------
   logic framing_err_q, overrun_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         framing_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         // A new error event in the clearing cycle wins over the clear.
         framing_err_q <= rx_ferr |
                          (framing_err_q & ~(wr_status & dataIn[StatFramingErr]));
         overrun_q     <= (rx_push & rx_full & ~rx_pop) |
                          (overrun_q & ~(wr_status & dataIn[StatOverrun]));
      end
   end

   assign rxReady = rx_valid;

   always_comb begin
      dataOut = '0;
      case (addr)
         AddrData: begin
            if (rx_valid) dataOut = rx_head;
         end
         AddrStatus: begin
            dataOut[StatRxValid]    = rx_valid;
            dataOut[StatTxBusy]     = tx_busy;
            dataOut[StatOverrun]    = overrun_q;
            dataOut[StatFramingErr] = framing_err_q;
         end
         default: dataOut = '0;
      endcase
   end

endmodule

// File: doc/serial_uart.md
SERIAL_UART -- requirements
Module: serial_uart

Interface
REQ-001 SHALL have parameter clocksPerBit, default 104, meaning clk cycles per serial bit (legal range 4..255).
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  4  register select, processor memAddr[3:0].
REQ-005 SHALL have port dataIn  input  8  processor write data.
REQ-006 SHALL have port dataOut  output  8  register read data.
REQ-007 SHALL have port strobe  input  1  one-cycle access pulse, already qualified by address decode.
REQ-008 SHALL have port write  input  1  high = write access during strobe.
REQ-009 SHALL have port serialIn  input  1  asynchronous RX line, idle high.
REQ-010 SHALL have port serialOut  output  1  TX line, idle high.
REQ-011 SHALL have port rxReady  output  1  high while at least one received byte is unread.

Function
REQ-012 SHALL map registers: addr 0 = DATA, addr 1 = STATUS; other addresses read 0 and ignore writes.
REQ-013 SHALL drive dataOut combinationally from addr: DATA = oldest unread RX byte (0 if none); STATUS = {4'b0, framingErr, overrun, txBusy, rxValid}.
REQ-014 SHALL pop the oldest RX byte on the clock edge where strobe & ~write & addr==0; read with nothing pending has no effect.
REQ-015 SHALL, on strobe & write & addr==1, clear each of framingErr/overrun whose dataIn bit (3/2) is 1.
REQ-016 SHALL, on strobe & write & addr==0 with TX idle, latch dataIn and drive serialOut low on the following edge (1-cycle latency).
REQ-017 SHALL ignore DATA writes while txBusy=1; the in-flight frame is unaffected.
REQ-018 SHALL transmit TX frames as start(0), 8 data bits LSB first, stop(1), each held exactly clocksPerBit cycles; TX states IDLE, START, DATA, STOP.
REQ-019 SHALL assert txBusy from the cycle after the accepted write until the end of the stop bit, then return to IDLE with serialOut=1.
REQ-020 SHALL pass serialIn through a 2-flop synchronizer before any use.
REQ-021 SHALL run an RX FSM with states IDLE, START, DATA, STOP: IDLE→START on synchronized falling edge; START re-samples at clocksPerBit/2 and returns to IDLE if high (glitch rejection); DATA samples 8 bits at mid-bit, LSB first; STOP samples mid-bit.
REQ-022 SHALL push the byte on stop=1; on stop=0 SHALL discard it, set framingErr, and wait for line high before re-entering IDLE.
REQ-023 SHALL, on a push while receive storage is full, drop the new byte, keep stored bytes, set overrun.
REQ-024 SHALL, when pop and push occur in the same cycle, perform both; storage count unchanged when full.
REQ-025 SHALL keep rxValid and rxReady identical, high iff storage non-empty.
REQ-026 SHALL run RX and TX fully independently; simultaneous activity never stalls either.

Reset
REQ-027 SHALL on reset low immediately force: serialOut=1, txBusy=0, both FSMs IDLE, storage empty, rxReady=0, framingErr=0, overrun=0, synchronizer flops=1, bit counters=0.
REQ-028 SHALL abort any frame in progress when reset asserts mid-frame; first TX after release starts a fresh frame.

Configuration
REQ-029 SHALL honor macro SERIAL_UART_RX_FIFO_EN: defined = 4-entry RX FIFO with wrapping 2-bit read/write pointers and 3-bit count; undefined = single holding register (depth 1).
REQ-030 SHALL keep register map, status bits and all other behaviour identical in both configurations except overrun threshold.

Structure
REQ-031 SHALL place register offsets, STATUS bit positions, and RX/TX state encodings in shared package serial_uart_pkg.
REQ-032 SHALL implement the receiver (synchronizer, RX FSM, sampling) as sub-module serial_uart_rx; TX, register file and storage stay in serial_uart.

Verification (clocksPerBit=16)
REQ-033 SHALL verify TX: write 0xA5 to DATA -> serialOut low next cycle, bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high; txBusy high 160 cycles.
REQ-034 SHALL verify RX: drive frame 0x3C -> rxReady rises after stop mid-sample; DATA read returns 0x3C; rxReady falls next edge.
REQ-035 SHALL verify glitch/framing: 4-cycle low pulse -> no byte; frame 0x55 with stop=0 -> STATUS=0x08, nothing stored; write STATUS 0x08 -> STATUS=0x00.
REQ-036 SHALL verify overrun: with FIFO_EN send 5 bytes 0x01..0x05 unread -> reads return 0x01..0x04, overrun=1; without macro, 2 bytes -> read 0x01, overrun=1.
REQ-037 SHALL verify reset mid-TX: assert reset during bit 3 of 0xFF -> serialOut=1, txBusy=0 immediately; write 0x00 after release -> full fresh frame.
REQ-038 SHALL verify concurrency: write 0x81 to DATA while receiving 0x7E -> both frames correct; busy write of 0x11 ignored.
